mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 17 +
 rtl/lsu_lane_align.sv | 47 ++++
 rtl/mem_access_unit.sv | 149 ++++++++++++++
 tb/tb_mem_access_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access stage: access size codes, FSM states and constants.
package mem_access_unit_pkg;

    localparam logic [2:0] RwByte  = 3'b000;
    localparam logic [2:0] RwHalf  = 3'b001;
    localparam logic [2:0] RwWord  = 3'b010;
    localparam logic [2:0] RwByteU = 3'b100;
    localparam logic [2:0] RwHalfU = 3'b101;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    typedef enum logic [0:0] {
        StIdle,
        StWait
    } mau_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: store byte enables and replication, load lane select and extension.
module lsu_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  rw_type_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] load_raw_i,
    output logic        aligned_o,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = 8'(load_raw_i >> {addr_lo_i, 3'b000});
    assign half_lane = addr_lo_i[1] ? load_raw_i[31:16] : load_raw_i[15:0];

    always_comb begin
        aligned_o   = 1'b1;
        be_o        = 4'b1111;
        wdata_o     = store_data_i;
        load_data_o = load_raw_i;
        case (rw_type_i)
            RwByte, RwByteU: begin
                be_o        = 4'b0001 << addr_lo_i;
                wdata_o     = {4{store_data_i[7:0]}};
                // Bit 2 of the size code selects zero extension.
                load_data_o = rw_type_i[2] ? {24'h0, byte_lane}
                                           : {{24{byte_lane[7]}}, byte_lane};
            end
            RwHalf, RwHalfU: begin
                aligned_o   = ~addr_lo_i[0];
                be_o        = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o     = {2{store_data_i[15:0]}};
                load_data_o = rw_type_i[2] ? {16'h0, half_lane}
                                           : {{16{half_lane[15]}}, half_lane};
            end
            default: begin
                aligned_o = (addr_lo_i == 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: data memory handshake FSM with ack timeout, plus the MEM/WB pipeline registers.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] rs2_data_i,
    input  logic [31:0] imme_i,
    input  logic [31:0] pc_order_i,
    input  logic [4:0]  rd_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic        lui_i,
    input  logic        jal_i,
    input  logic        jalr_i,
    input  logic        reg_write_i,
    input  logic [2:0]  rw_type_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_be_o,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_ack_i,
    output logic        stall_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic [31:0] wb_data_o,
    output logic [4:0]  wb_rd_o,
    output logic        wb_reg_write_o
);

    localparam int unsigned CntW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(ACK_TIMEOUT - 1);

    mau_state_e      state_q;
    logic [CntW-1:0] cnt_q;
    logic            bus_err_q;
    logic [31:0]     wb_data_q;
    logic [4:0]      wb_rd_q;
    logic            wb_reg_write_q;

    logic        access;
    logic        aligned;
    logic        req;
    logic        timeout;
    logic        stall;
    logic        bubble;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] load_data;
    logic [31:0] wb_sel;

    lsu_lane_align u_lane_align (
        .rw_type_i    (rw_type_i),
        .addr_lo_i    (alu_result_i[1:0]),
        .store_data_i (rs2_data_i),
        .load_raw_i   (dmem_rdata_i),
        .aligned_o    (aligned),
        .be_o         (lane_be),
        .wdata_o      (lane_wdata),
        .load_data_o  (load_data)
    );

    assign access = mem_read_i | mem_write_i;

    // Inputs are held while stalled, so WAIT keeps requesting without re-checking them.
    always_comb begin
        req        = 1'b0;
        misalign_o = 1'b0;
        if (rst_n) begin
            if (state_q == StWait) begin
                req = 1'b1;
            end else if (access) begin
                req        = aligned;
                misalign_o = ~aligned;
            end
        end
    end

    // Stall is released in the timeout cycle so upstream moves on while the bubble is captured.
    assign timeout = (state_q == StWait) && !dmem_ack_i && (cnt_q == CntMax);
    assign stall   = req && !dmem_ack_i && !timeout;
    assign bubble  = stall || timeout || misalign_o;

    always_comb begin
        wb_sel = alu_result_i;
        if (mem_read_i) begin
            wb_sel = load_data;
        end else if (jal_i || jalr_i) begin
            wb_sel = pc_order_i;
        end else if (lui_i) begin
            wb_sel = imme_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            bus_err_q      <= 1'b0;
            wb_data_q      <= ZeroWord;
            wb_rd_q        <= 5'd0;
            wb_reg_write_q <= 1'b0;
        end else begin
            bus_err_q <= timeout;
            case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (req && !dmem_ack_i) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (dmem_ack_i || timeout) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else if (cnt_q != CntMax) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (bubble) begin
                wb_reg_write_q <= 1'b0;
            end else begin
                wb_data_q      <= wb_sel;
                wb_rd_q        <= rd_i;
                wb_reg_write_q <= reg_write_i && (rd_i != 5'd0);
            end
        end
    end

    assign dmem_req_o     = req;
    assign dmem_we_o      = req && mem_write_i;
    assign dmem_be_o      = dmem_we_o ? lane_be : 4'b0000;
    assign dmem_addr_o    = {alu_result_i[31:2], 2'b00};
    assign dmem_wdata_o   = lane_wdata;
    assign stall_o        = stall;
    assign bus_err_o      = bus_err_q;
    assign wb_data_o      = wb_data_q;
    assign wb_rd_o        = wb_rd_q;
    assign wb_reg_write_o = wb_reg_write_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: single-cycle vector table plus multi-cycle handshake cases.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] alu_result, rs2_data, imme, pc_order, dmem_rdata;
    logic [4:0]  rd;
    logic        mem_read, mem_write, lui, jal, jalr, reg_write, dmem_ack;
    logic [2:0]  rw_type;
    logic        dmem_req, dmem_we, stall, misalign, bus_err, wb_reg_write;
    logic [31:0] dmem_addr, dmem_wdata, wb_data;
    logic [3:0]  dmem_be;
    logic [4:0]  wb_rd;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ACK_TIMEOUT(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alu_result_i   (alu_result),
        .rs2_data_i     (rs2_data),
        .imme_i         (imme),
        .pc_order_i     (pc_order),
        .rd_i           (rd),
        .mem_read_i     (mem_read),
        .mem_write_i    (mem_write),
        .lui_i          (lui),
        .jal_i          (jal),
        .jalr_i         (jalr),
        .reg_write_i    (reg_write),
        .rw_type_i      (rw_type),
        .dmem_req_o     (dmem_req),
        .dmem_we_o      (dmem_we),
        .dmem_addr_o    (dmem_addr),
        .dmem_wdata_o   (dmem_wdata),
        .dmem_be_o      (dmem_be),
        .dmem_rdata_i   (dmem_rdata),
        .dmem_ack_i     (dmem_ack),
        .stall_o        (stall),
        .misalign_o     (misalign),
        .bus_err_o      (bus_err),
        .wb_data_o      (wb_data),
        .wb_rd_o        (wb_rd),
        .wb_reg_write_o (wb_reg_write)
    );

    // ctl = {mem_read, mem_write, lui, jal, jalr, reg_write, ack}
    // eflg = {req, we, misalign, wb_reg_write}
    typedef struct {
        logic [2:0]  rw;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [6:0]  ctl;
        logic [31:0] rdata;
        logic [3:0]  eflg;
        logic [3:0]  ebe;
        logic [31:0] ewdata;
        logic [31:0] ewb;
        logic [4:0]  erd;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic clear_inputs();
        alu_result = '0; rs2_data = '0; imme = '0; pc_order = '0; dmem_rdata = '0;
        rd = '0; rw_type = 3'b010;
        {mem_read, mem_write, lui, jal, jalr, reg_write, dmem_ack} = 7'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        vecs[0]  = '{3'b010, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 5'd5, 7'b0000010, 32'h0,
                     4'b0001, 4'h0, 32'h0, 32'h1234_5678, 5'd5};
        vecs[1]  = '{3'b010, 32'h11, 32'h0, 32'hABCD_E000, 32'h0, 5'd6, 7'b0010010, 32'h0,
                     4'b0001, 4'h0, 32'h0, 32'hABCD_E000, 5'd6};
        vecs[2]  = '{3'b010, 32'h99, 32'h0, 32'h0, 32'h48, 5'd1, 7'b0001010, 32'h0,
                     4'b0001, 4'h0, 32'h0, 32'h48, 5'd1};
        vecs[3]  = '{3'b010, 32'h99, 32'h0, 32'h0, 32'h48, 5'd0, 7'b0001010, 32'h0,
                     4'b0000, 4'h0, 32'h0, 32'h48, 5'd0};
        vecs[4]  = '{3'b000, 32'h203, 32'h0, 32'h0, 32'h0, 5'd7, 7'b1000011, 32'h8011_2233,
                     4'b1001, 4'h0, 32'h0, 32'hFFFF_FF80, 5'd7};
        vecs[5]  = '{3'b100, 32'h203, 32'h0, 32'h0, 32'h0, 5'd7, 7'b1000011, 32'h8011_2233,
                     4'b1001, 4'h0, 32'h0, 32'h0000_0080, 5'd7};
        vecs[6]  = '{3'b001, 32'h102, 32'h0, 32'h0, 32'h0, 5'd7, 7'b1000011, 32'h8001_7FFF,
                     4'b1001, 4'h0, 32'h0, 32'hFFFF_8001, 5'd7};
        vecs[7]  = '{3'b101, 32'h100, 32'h0, 32'h0, 32'h0, 5'd7, 7'b1000011, 32'h8001_F00D,
                     4'b1001, 4'h0, 32'h0, 32'h0000_F00D, 5'd7};
        vecs[8]  = '{3'b010, 32'h40, 32'h0, 32'h0, 32'h77, 5'd9, 7'b1001011, 32'hCAFE_BABE,
                     4'b1001, 4'h0, 32'h0, 32'hCAFE_BABE, 5'd9};
        vecs[9]  = '{3'b000, 32'h101, 32'hA5, 32'h0, 32'h0, 5'd0, 7'b0100001, 32'h0,
                     4'b1100, 4'b0010, 32'hA5A5_A5A5, 32'h101, 5'd0};
        vecs[10] = '{3'b001, 32'h106, 32'h1234_BEEF, 32'h0, 32'h0, 5'd0, 7'b0100001, 32'h0,
                     4'b1100, 4'b1100, 32'hBEEF_BEEF, 32'h106, 5'd0};
        vecs[11] = '{3'b010, 32'h104, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd0, 7'b0100001, 32'h0,
                     4'b1100, 4'b1111, 32'hDEAD_BEEF, 32'h104, 5'd0};
        vecs[12] = '{3'b001, 32'h3, 32'h1111, 32'h0, 32'h0, 5'd3, 7'b0100010, 32'h0,
                     4'b0010, 4'h0, 32'h0, 32'h104, 5'd0};
        vecs[13] = '{3'b010, 32'h42, 32'h0, 32'h0, 32'h0, 5'd4, 7'b1000010, 32'h0,
                     4'b0010, 4'h0, 32'h0, 32'h104, 5'd0};
        vecs[14] = '{3'b010, 32'h7, 32'h0, 32'h5000, 32'h200, 5'd2, 7'b0010110, 32'h0,
                     4'b0001, 4'h0, 32'h0, 32'h200, 5'd2};
        vecs[15] = '{3'b010, 32'h55, 32'h0, 32'h0, 32'h0, 5'd8, 7'b0000011, 32'h0,
                     4'b0001, 4'h0, 32'h0, 32'h55, 5'd8};
        vecs[16] = '{3'b010, 32'h66, 32'h0, 32'h0, 32'h0, 5'd9, 7'b0000010, 32'h0,
                     4'b0001, 4'h0, 32'h0, 32'h66, 5'd9};

        // Reset, with an access presented while reset is held.
        clear_inputs();
        rst_n = 1'b0;
        alu_result = 32'h100;
        mem_read = 1'b1;
        #7;
        check("reset req", 32'(dmem_req), 32'h0);
        check("reset stall", 32'(stall), 32'h0);
        check("reset wb_data", wb_data, 32'h0);
        check("reset wb_rd", 32'(wb_rd), 32'h0);
        check("reset wb_we", 32'(wb_reg_write), 32'h0);
        check("reset bus_err", 32'(bus_err), 32'h0);
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 17; i++) begin
            rw_type = vecs[i].rw; alu_result = vecs[i].addr; rs2_data = vecs[i].wdat;
            imme = vecs[i].imm; pc_order = vecs[i].pc; rd = vecs[i].rd;
            dmem_rdata = vecs[i].rdata;
            {mem_read, mem_write, lui, jal, jalr, reg_write, dmem_ack} = vecs[i].ctl;
            #3;
            check($sformatf("row%0d req", i), 32'(dmem_req), 32'(vecs[i].eflg[3]));
            check($sformatf("row%0d we", i), 32'(dmem_we), 32'(vecs[i].eflg[2]));
            check($sformatf("row%0d misalign", i), 32'(misalign), 32'(vecs[i].eflg[1]));
            check($sformatf("row%0d be", i), 32'(dmem_be), 32'(vecs[i].ebe));
            check($sformatf("row%0d stall", i), 32'(stall), 32'h0);
            if (vecs[i].eflg[2]) check($sformatf("row%0d wdata", i), dmem_wdata, vecs[i].ewdata);
            if (vecs[i].eflg[3])
                check($sformatf("row%0d addr", i), dmem_addr, {vecs[i].addr[31:2], 2'b00});
            step();
            check($sformatf("row%0d wb_data", i), wb_data, vecs[i].ewb);
            check($sformatf("row%0d wb_rd", i), 32'(wb_rd), 32'(vecs[i].erd));
            check($sformatf("row%0d wb_we", i), 32'(wb_reg_write), 32'(vecs[i].eflg[0]));
            check($sformatf("row%0d bus_err", i), 32'(bus_err), 32'h0);
        end
        clear_inputs();
        step();

        // Word store acked on the third cycle after the request.
        alu_result = 32'h104; rs2_data = 32'hDEAD_BEEF; mem_write = 1'b1; rw_type = 3'b010;
        rd = 5'd5;
        n = 0;
        for (int c = 0; c < 3; c++) begin
            #3;
            if (stall) n++;
            if (c == 0) begin
                check("sw be", 32'(dmem_be), 32'hF);
                check("sw wdata", dmem_wdata, 32'hDEAD_BEEF);
                check("sw addr", dmem_addr, 32'h104);
            end
            step();
        end
        dmem_ack = 1'b1;
        #3;
        check("sw ack stall", 32'(stall), 32'h0);
        check("sw ack req", 32'(dmem_req), 32'h1);
        step();
        clear_inputs();
        check("sw stall cycles", 32'(n), 32'd3);
        check("sw wb_we", 32'(wb_reg_write), 32'h0);
        step();

        // Byte load acked in the first wait cycle, signed.
        alu_result = 32'h203; rw_type = 3'b000; mem_read = 1'b1; rd = 5'd7; reg_write = 1'b1;
        #3;
        check("lb req stall", 32'(stall), 32'h1);
        step();
        dmem_ack = 1'b1; dmem_rdata = 32'h80AB_CDEF;
        #3;
        check("lb ack stall", 32'(stall), 32'h0);
        step();
        clear_inputs();
        check("lb wb_data", wb_data, 32'hFFFF_FF80);
        check("lb wb_we", 32'(wb_reg_write), 32'h1);
        check("lb wb_rd", 32'(wb_rd), 32'd7);
        step();

        // Load never acked: timeout after 16 wait cycles.
        alu_result = 32'h80; rw_type = 3'b010; mem_read = 1'b1; rd = 5'd10; reg_write = 1'b1;
        n = 0;
        #3;
        for (int c = 0; c < 40 && stall; c++) begin
            n++;
            @(posedge clk);
            #3;
        end
        check("to stall cycles", 32'(n), 32'd16);
        check("to last req", 32'(dmem_req), 32'h1);
        check("to early bus_err", 32'(bus_err), 32'h0);
        step();
        clear_inputs();
        #3;
        check("to bus_err", 32'(bus_err), 32'h1);
        check("to req dropped", 32'(dmem_req), 32'h0);
        check("to stall", 32'(stall), 32'h0);
        check("to wb_we", 32'(wb_reg_write), 32'h0);
        @(posedge clk);
        #4;
        check("to bus_err pulse", 32'(bus_err), 32'h0);
        step();

        // Ack in the timeout cycle wins.
        alu_result = 32'h84; rw_type = 3'b010; mem_read = 1'b1; rd = 5'd11; reg_write = 1'b1;
        for (int c = 0; c < 16; c++) step();
        dmem_ack = 1'b1; dmem_rdata = 32'h1357_9BDF;
        #3;
        check("ackto stall", 32'(stall), 32'h0);
        step();
        clear_inputs();
        #3;
        check("ackto bus_err", 32'(bus_err), 32'h0);
        check("ackto wb_data", wb_data, 32'h1357_9BDF);
        check("ackto wb_we", 32'(wb_reg_write), 32'h1);
        step();

        // Reset while waiting; a late ack must be ignored.
        alu_result = 32'h80; rw_type = 3'b010; mem_read = 1'b1; rd = 5'd12; reg_write = 1'b1;
        step();
        #1;
        rst_n = 1'b0;
        #1;
        check("rstw req", 32'(dmem_req), 32'h0);
        check("rstw stall", 32'(stall), 32'h0);
        check("rstw wb_data", wb_data, 32'h0);
        check("rstw wb_we", 32'(wb_reg_write), 32'h0);
        clear_inputs();
        step();
        rst_n = 1'b1;
        step();
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        #3;
        check("rstw late req", 32'(dmem_req), 32'h0);
        check("rstw late stall", 32'(stall), 32'h0);
        step();
        clear_inputs();
        #3;
        check("rstw late wb_data", wb_data, 32'h0);
        check("rstw late wb_rd", 32'(wb_rd), 32'h0);
        check("rstw late wb_we", 32'(wb_reg_write), 32'h0);
        check("rstw late bus_err", 32'(bus_err), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
